// File: rtl/wb_unit.sv
// Writeback stage: retires one EXU instruction at a time into the register file,
// aligning and extending load data and dropping writes to x0 and faulting loads.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for a new instruction from EXU
//   WAIT_MEM | load accepted, waiting for the mem_rvalid pulse
//   WRITE    | single cycle: rd_we/wb_done/wb_err presented to regfile/IFU
module wb_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd_addr,
    input  logic [DATA_WIDTH-1:0] exu_result,
    input  logic                  exu_is_load,
    input  logic [2:0]            exu_funct3,
    input  logic [1:0]            exu_addr_low,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rd_we,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wb_done,
    output logic                  wb_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]            ld_funct3_q, ld_funct3_d;
    logic [1:0]            ld_lane_q, ld_lane_d;

    logic                  rd_we_q, rd_we_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wb_done_q, wb_done_d;
    logic                  wb_err_q, wb_err_d;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_fault;

    // Load alignment/extension from the fields captured when the load was accepted.
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = ld_lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data  = '0;
        ld_fault = 1'b0;
        case (ld_lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        case (ld_funct3_q)
            F3_LB:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            F3_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            F3_LH: begin
                if (ld_lane_q[0]) ld_fault = 1'b1;
                else              ld_data  = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            end
            F3_LHU: begin
                if (ld_lane_q[0]) ld_fault = 1'b1;
                else              ld_data  = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            end
            F3_LW: begin
                if (ld_lane_q != 2'd0) ld_fault = 1'b1;
                else                   ld_data  = mem_rdata;
            end
            default: ld_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (exu_valid) state_d = exu_is_load ? ST_WAIT_MEM : ST_WRITE;
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are formed on the transition into WRITE.
    always_comb begin
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_lane_d   = ld_lane_q;
        rd_we_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        wb_done_d   = 1'b0;
        wb_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exu_valid) begin
                    ld_rd_d     = exu_rd_addr;
                    ld_funct3_d = exu_funct3;
                    ld_lane_d   = exu_addr_low;
                    if (!exu_is_load) begin
                        rd_we_d   = (exu_rd_addr != '0);
                        rd_addr_d = exu_rd_addr;
                        rd_data_d = exu_result;
                        wb_done_d = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    rd_we_d   = !ld_fault && (ld_rd_q != '0);
                    rd_addr_d = ld_rd_q;
                    rd_data_d = ld_fault ? '0 : ld_data;
                    wb_done_d = 1'b1;
                    wb_err_d  = ld_fault;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rd_q     <= '0;
            ld_funct3_q <= 3'b000;
            ld_lane_q   <= 2'd0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            wb_done_q   <= 1'b0;
            wb_err_q    <= 1'b0;
        end else begin
            ld_rd_q     <= ld_rd_d;
            ld_funct3_q <= ld_funct3_d;
            ld_lane_q   <= ld_lane_d;
            rd_we_q     <= rd_we_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            wb_done_q   <= wb_done_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign exu_ready = (state_q == ST_IDLE);
    assign rd_we     = rd_we_q;
    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign wb_done   = wb_done_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus randomized traffic
// compared against a behavioural load-extension model.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd_addr;
    logic [31:0] exu_result;
    logic        exu_is_load;
    logic [2:0]  exu_funct3;
    logic [1:0]  exu_addr_low;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wb_done;
    logic        wb_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd_addr  (exu_rd_addr),
        .exu_result   (exu_result),
        .exu_is_load  (exu_is_load),
        .exu_funct3   (exu_funct3),
        .exu_addr_low (exu_addr_low),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rd_we        (rd_we),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wb_done      (wb_done),
        .wb_err       (wb_err)
    );

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;

    // Reference: plain arithmetic on the raw word, no bit-slicing mirror of the RTL.
    function automatic exp_t ref_wb(input bit is_load, input int f3, input int lane,
                                    input logic [31:0] rdata, input logic [31:0] result,
                                    input int rd);
        exp_t e;
        longint unsigned w = rdata;
        longint unsigned b = (w >> (8 * lane)) % 256;
        longint unsigned h = (w >> (16 * (lane / 2))) % 65536;
        longint unsigned v = 0;
        e.err = 1'b0;
        if (!is_load) begin
            v = result;
        end else begin
            case (f3)
                0: v = (b >= 128) ? (b + 64'hFFFF_FF00) : b;
                4: v = b;
                1: if (lane % 2 == 1) e.err = 1'b1; else v = (h >= 32768) ? (h + 64'hFFFF_0000) : h;
                5: if (lane % 2 == 1) e.err = 1'b1; else v = h;
                2: if (lane != 0) e.err = 1'b1; else v = w;
                default: e.err = 1'b1;
            endcase
        end
        e.data = e.err ? 32'h0 : v[31:0];
        e.we   = !e.err && (rd != 0);
        return e;
    endfunction

    // Drives one instruction and reports what the DUT presented; callers judge.
    task automatic run_insn(input logic [4:0] rd, input logic [31:0] result, input bit is_load,
                            input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] rdata,
                            input int delay, input bit hold_valid,
                            output logic o_we, output logic [4:0] o_addr, output logic [31:0] o_data,
                            output logic o_done, output logic o_err,
                            output int busy_bad, output int early_wr,
                            output logic post_we, output logic post_ready);
        busy_bad = 0;
        early_wr = 0;
        exu_valid    = 1'b1;
        exu_rd_addr  = rd;
        exu_result   = result;
        exu_is_load  = is_load;
        exu_funct3   = f3;
        exu_addr_low = lane;
        mem_rdata    = $urandom;
        @(negedge clk);
        if (is_load) begin
            if (!hold_valid) exu_valid = 1'b0;
            for (int i = 0; i <= delay; i++) begin
                if (i > 0) @(negedge clk);
                if (exu_ready !== 1'b0) busy_bad++;
                if (rd_we !== 1'b0 || wb_done !== 1'b0) early_wr++;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        o_we   = rd_we;
        o_addr = rd_addr;
        o_data = rd_data;
        o_done = wb_done;
        o_err  = wb_err;
        exu_valid = 1'b0;
        @(negedge clk);
        post_we    = rd_we;
        post_ready = exu_ready;
    endtask

    task automatic test_reset();
        int stray;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rd_we !== 1'b0)     $display("FAIL reset_rd_we got=%b exp=0", rd_we);     else n_pass++;
        n_checks++; if (wb_done !== 1'b0)   $display("FAIL reset_wb_done got=%b exp=0", wb_done); else n_pass++;
        n_checks++; if (rd_data !== 32'h0)  $display("FAIL reset_rd_data got=%h exp=0", rd_data); else n_pass++;
        n_checks++; if (rd_addr !== 5'h0)   $display("FAIL reset_rd_addr got=%h exp=0", rd_addr); else n_pass++;
        n_checks++; if (wb_err !== 1'b0)    $display("FAIL reset_wb_err got=%b exp=0", wb_err);   else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (exu_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", exu_ready); else n_pass++;
        // Load parked in WAIT_MEM, then reset; the late memory reply must be dropped.
        exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd_addr = 5'd9; exu_funct3 = 3'b010; exu_addr_low = 2'd0;
        @(negedge clk);
        exu_valid = 1'b0;
        n_checks++; if (exu_ready !== 1'b0) $display("FAIL midrst_waitmem got=%b exp=0", exu_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rd_we !== 1'b0 || wb_done !== 1'b0) stray++;
        end
        n_checks++; if (stray !== 0) $display("FAIL midrst_discard got=%0d writes exp=0", stray); else n_pass++;
        n_checks++; if (exu_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", exu_ready); else n_pass++;
    endtask

    task automatic test_nonload();
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        run_insn(5'd5, 32'hDEADBEEF, 1'b0, 3'b000, 2'd0, 32'h0, 0, 1'b0, we, a, d, done, err, bb, ew, pwe, prdy);
        n_checks++; if (we !== 1'b1)          $display("FAIL nonload_we got=%b exp=1", we);       else n_pass++;
        n_checks++; if (a !== 5'd5)           $display("FAIL nonload_addr got=%0d exp=5", a);     else n_pass++;
        n_checks++; if (d !== 32'hDEADBEEF)   $display("FAIL nonload_data got=%h exp=deadbeef", d); else n_pass++;
        n_checks++; if (done !== 1'b1)        $display("FAIL nonload_done got=%b exp=1", done);   else n_pass++;
        n_checks++; if (err !== 1'b0)         $display("FAIL nonload_err got=%b exp=0", err);     else n_pass++;
        n_checks++; if (pwe !== 1'b0)         $display("FAIL nonload_post_we got=%b exp=0", pwe); else n_pass++;
        n_checks++; if (prdy !== 1'b1)        $display("FAIL nonload_post_ready got=%b exp=1", prdy); else n_pass++;
    endtask

    task automatic test_x0();
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        run_insn(5'd0, 32'h1234, 1'b0, 3'b000, 2'd0, 32'h0, 0, 1'b0, we, a, d, done, err, bb, ew, pwe, prdy);
        n_checks++; if (done !== 1'b1) $display("FAIL x0_done got=%b exp=1", done); else n_pass++;
        n_checks++; if (we !== 1'b0)   $display("FAIL x0_we got=%b exp=0", we);     else n_pass++;
        n_checks++; if (err !== 1'b0)  $display("FAIL x0_err got=%b exp=0", err);   else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  lns  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        for (int i = 0; i < 5; i++) begin
            run_insn(5'(10 + i), 32'h0, 1'b1, f3s[i], lns[i], 32'h80FF7F01, i, 1'b0,
                     we, a, d, done, err, bb, ew, pwe, prdy);
            n_checks++;
            if (we !== 1'b1 || d !== exps[i] || a !== 5'(10 + i) || done !== 1'b1 || err !== 1'b0 || ew !== 0)
                $display("FAIL load_ext[%0d] got we=%b addr=%0d data=%h done=%b err=%b early=%0d exp we=1 addr=%0d data=%h done=1 err=0 early=0",
                         i, we, a, d, done, err, ew, 10 + i, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_faults();
        logic [2:0] f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [1:0] lns [3] = '{2'd2, 2'd1, 2'd0};
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        for (int i = 0; i < 3; i++) begin
            run_insn(5'd7, 32'h0, 1'b1, f3s[i], lns[i], 32'hFFFFFFFF, 1, 1'b0,
                     we, a, d, done, err, bb, ew, pwe, prdy);
            n_checks++;
            if (we !== 1'b0 || d !== 32'h0 || done !== 1'b1 || err !== 1'b1)
                $display("FAIL fault[%0d] got we=%b data=%h done=%b err=%b exp we=0 data=0 done=1 err=1",
                         i, we, d, done, err);
            else n_pass++;
        end
    endtask

    task automatic test_hold_valid();
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        run_insn(5'd3, 32'h0, 1'b1, 3'b010, 2'd0, 32'h0BADC0DE, 10, 1'b1,
                 we, a, d, done, err, bb, ew, pwe, prdy);
        n_checks++; if (bb !== 0)  $display("FAIL hold_ready_low got=%0d ready-high cycles exp=0", bb); else n_pass++;
        n_checks++;
        if (ew !== 0 || we !== 1'b1 || d !== 32'h0BADC0DE || pwe !== 1'b0)
            $display("FAIL hold_single_write got early=%0d we=%b data=%h post_we=%b exp early=0 we=1 data=0badc0de post_we=0",
                     ew, we, d, pwe);
        else n_pass++;
    endtask

    task automatic test_stray_rvalid();
        int stray = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rd_we !== 1'b0 || wb_done !== 1'b0 || exu_ready !== 1'b1) stray++;
            @(negedge clk);
        end
        n_checks++; if (stray !== 0) $display("FAIL stray_rvalid got=%0d bad cycles exp=0", stray); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds [4];
        logic [31:0] res [4];
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            rds[i] = 5'($urandom_range(1, 31));
            res[i] = $urandom;
        end
        exu_valid = 1'b1; exu_is_load = 1'b0;
        exu_rd_addr = rds[0]; exu_result = res[0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                if (rd_we !== 1'b1 || wb_done !== 1'b1 || rd_addr !== rds[k/2] || rd_data !== res[k/2] || exu_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                             k/2, rd_we, rd_addr, rd_data, rds[k/2], res[k/2]);
                end
                if (k < 6) begin
                    exu_rd_addr = rds[k/2 + 1];
                    exu_result  = res[k/2 + 1];
                end else exu_valid = 1'b0;
            end else if (rd_we !== 1'b0 || wb_done !== 1'b0 || exu_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_gap[%0d] got we=%b done=%b ready=%b exp we=0 done=0 ready=1",
                         k, rd_we, wb_done, exu_ready);
            end
        end
        exu_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bad !== 0) $display("FAIL b2b got=%0d bad cycles exp=0", bad); else n_pass++;
    endtask

    task automatic test_random();
        logic we, done, err, pwe, prdy; logic [4:0] a; logic [31:0] d; int bb, ew;
        exp_t e;
        for (int it = 0; it < 40; it++) begin
            bit          ld   = ($urandom_range(0, 3) != 0);
            logic [2:0]  f3   = 3'($urandom_range(0, 7));
            logic [1:0]  ln   = 2'($urandom_range(0, 3));
            logic [4:0]  rd   = 5'($urandom_range(0, 31));
            logic [31:0] rdat = $urandom;
            logic [31:0] res  = $urandom;
            int          dly  = $urandom_range(0, 4);
            e = ref_wb(ld, int'(f3), int'(ln), rdat, res, int'(rd));
            run_insn(rd, res, ld, f3, ln, rdat, dly, 1'b0, we, a, d, done, err, bb, ew, pwe, prdy);
            n_checks++;
            if (we !== e.we || err !== e.err || done !== 1'b1 || pwe !== 1'b0 || prdy !== 1'b1
                || ((e.we || e.err) && d !== e.data) || (e.we && a !== rd))
                $display("FAIL random[%0d] ld=%0d f3=%0d lane=%0d got we=%b err=%b data=%h addr=%0d done=%b exp we=%b err=%b data=%h addr=%0d",
                         it, ld, f3, ln, we, err, d, a, done, e.we, e.err, e.data, rd);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; exu_valid = 1'b0; exu_rd_addr = '0; exu_result = '0; exu_is_load = 1'b0;
        exu_funct3 = '0; exu_addr_low = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_nonload();
        test_x0();
        test_load_ext();
        test_faults();
        test_hold_valid();
        test_stray_rvalid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
